weight_scan_rx: RTL
===================

WEIGHT_SCAN_RX -- requirements
Module: weight_scan_rx

Interface
REQ-001 SHALL have parameter TAPS, default 256, meaning number of weight words per complete scan.
REQ-002 SHALL have parameter M, default 8, meaning index width, where TAPS = 2^M.
REQ-003 SHALL have parameter WORD_W, default 26, meaning bits per scanned weight word.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning depth of the output word buffer (power of two, at least 2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port scan_en, input, 1 bit: scan window, driven in parallel with the FIR scan_en.
REQ-008 SHALL have port scan_in, input, 1 bit: serial weight stream from the FIR scan_out, LSB first.
REQ-009 SHALL have port w_out, output, WORD_W bits: head-of-buffer weight word (signed Q format, unchanged bits).
REQ-010 SHALL have port w_idx, output, M bits: scan order index of w_out (0 = first word scanned).
REQ-011 SHALL have port w_valid, output, 1 bit: w_out and w_idx are valid.
REQ-012 SHALL have port w_ready, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when TAPS words have been captured.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, a completed word was dropped.
REQ-015 SHALL have port busy, output, 1 bit: high while in SHIFT state.

Function
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 SHALL move IDLE->SHIFT on a scan_en rising edge, clearing bit_cnt, word_cnt and overflow; the bit sampled on that same cycle is bit 0 of word 0.
REQ-018 SHALL, in SHIFT with scan_en=1, shift scan_in into a WORD_W-bit register MSB-side (LSB first) each cycle and increment bit_cnt over 0..WORD_W-1.
REQ-019 SHALL, on the cycle bit_cnt = WORD_W-1, form the completed word including the current scan_in bit, push {word, word_cnt} into the FIFO, wrap bit_cnt to 0 and increment word_cnt.
REQ-020 SHALL make a pushed word visible on w_out/w_valid on the cycle after the push when the FIFO was empty (1-cycle latency).
REQ-021 SHALL, on a push that completes word TAPS-1, go to DONE and pulse done for exactly one cycle on the following cycle.
REQ-022 SHALL, in DONE, ignore scan_in and return to IDLE when scan_en=0.
REQ-023 SHALL, if scan_en falls in SHIFT, discard the partial word, return to IDLE without a done pulse, and keep FIFO contents.
REQ-024 SHALL pop the FIFO on w_valid & w_ready; w_out/w_idx SHALL hold stable while w_valid=1 and w_ready=0.
REQ-025 SHALL, when the FIFO is full and a word completes without a same-cycle pop, drop the new word, set overflow, and still advance word_cnt.
REQ-026 SHALL, when full with a simultaneous push and pop, accept both with no overflow.
REQ-027 SHALL keep the FIFO occupancy count in the range 0..FIFO_DEPTH and SHALL wrap the read/write pointers modulo FIFO_DEPTH.
REQ-028 SHALL keep overflow set until rst or the next IDLE->SHIFT transition.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE and clear bit_cnt, word_cnt, the FIFO pointers and count, and the shift register; w_valid=0, done=0, overflow=0, busy=0, w_out=0, w_idx=0.
REQ-030 SHALL let rst override scan_en, including mid-word and mid-scan; a scan restarts only on a new scan_en rising edge after rst is released.

Verification
REQ-031 SHALL be verified as follows: rst, then scan_en=1 with serial 26'h2AAAAAA LSB first, w_ready=1 -> w_valid on the cycle after bit 25, w_out=26'h2AAAAAA, w_idx=0.
REQ-032 SHALL be verified as follows: a full scan with TAPS=4 of words 1, 26'h3FFFFFF, 26'h2000000, 5 and w_ready=1 -> four words in order with w_idx 0..3, a single done pulse, overflow=0.
REQ-033 SHALL be verified as follows: w_ready=0 during six words with FIFO_DEPTH=4 -> first four words retained, overflow=1, then draining yields w_idx 0..3.
REQ-034 SHALL be verified as follows: FIFO full with w_ready=1 on the completing cycle -> no overflow, occupancy stays 4.
REQ-035 SHALL be verified as follows: scan_en dropped after 13 bits of word 2 -> no push and no done, state IDLE, words 0-1 still poppable.
REQ-036 SHALL be verified as follows: rst asserted mid-word with FIFO holding 2 words -> next cycle w_valid=0, busy=0, overflow=0.

Source files
------------

// File: rtl/weight_scan_rx.sv
// Deserialises the LSB-first weight scan chain into WORD_W-bit words and
// buffers {word, scan index} pairs in a small FIFO for a ready/valid consumer.
module weight_scan_rx #(
    parameter int unsigned TAPS       = 256,
    parameter int unsigned M          = 8,
    parameter int unsigned WORD_W     = 26,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic [WORD_W-1:0] w_out,
    output logic [M-1:0]      w_idx,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              done,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_d;

    logic                scan_en_q;
    logic [WORD_W-2:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d, bit_cur;
    logic [M-1:0]        word_cnt, word_cnt_d, word_cur;
    logic [WORD_W-1:0]   mem_word [FIFO_DEPTH];
    logic [M-1:0]        mem_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
    logic [CNT_W-1:0]    count, count_d;
    logic                overflow_d, done_d;
    logic                shift_c, complete_c, push_c, pop_c, full_c;
    logic [WORD_W-1:0]   word_c;
    logic [M-1:0]        idx_c;

    // The partial register holds WORD_W-1 bits; the live scan_in bit completes the word.
    assign word_c = {scan_in, shift_q};
    assign pop_c  = w_valid & w_ready;
    assign full_c = (count == CNT_W'(FIFO_DEPTH));
    assign w_out  = mem_word[rd_ptr];
    assign w_idx  = mem_idx[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt;
        word_cnt_d = word_cnt;
        overflow_d = overflow;
        done_d     = 1'b0;
        shift_c    = 1'b0;
        complete_c = 1'b0;
        push_c     = 1'b0;
        bit_cur    = bit_cnt;
        word_cur   = word_cnt;
        idx_c      = word_cnt;

        case (state)
            IDLE: begin
                // The rising-edge cycle already carries bit 0 of word 0.
                if (scan_en && !scan_en_q) begin
                    state_d    = SHIFT;
                    shift_c    = 1'b1;
                    bit_cur    = '0;
                    word_cur   = '0;
                    overflow_d = 1'b0;
                end
            end
            SHIFT: begin
                if (scan_en) shift_c = 1'b1;
                else         state_d = IDLE;
            end
            DONE: begin
                if (!scan_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (shift_c) begin
            shift_d    = word_c[WORD_W-1:1];
            word_cnt_d = word_cur;
            if (bit_cur == BIT_W'(WORD_W - 1)) begin
                complete_c = 1'b1;
                bit_cnt_d  = '0;
                word_cnt_d = word_cur + 1'b1;
                idx_c      = word_cur;
                if (word_cur == M'(TAPS - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cur + 1'b1;
            end
        end

        // A full buffer still accepts a word when the head leaves on the same edge.
        if (complete_c) begin
            if (!full_c || pop_c) push_c = 1'b1;
            else                  overflow_d = 1'b1;
        end

        wr_ptr_d = push_c ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_d = pop_c  ? rd_ptr + 1'b1 : rd_ptr;
        case ({push_c, pop_c})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        scan_en_q <= scan_en;
        if (rst) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            w_valid  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bit_cnt  <= bit_cnt_d;
            word_cnt <= word_cnt_d;
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            count    <= count_d;
            w_valid  <= (count_d != '0);
            done     <= done_d;
            overflow <= overflow_d;
            busy     <= (state_d == SHIFT);
        end
    end

    // Word storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_word[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else if (push_c) begin
            mem_word[wr_ptr] <= word_c;
            mem_idx[wr_ptr]  <= idx_c;
        end
    end

endmodule
